mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_ctrl_if.sv | 41 ++++
 rtl/mem_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the single-port RAM controller.
//   DefAddrW / DefDataW / DefDepth : default address width, word width and implemented depth
//   state_e                        : controller FSM state encoding
package mem_pkg;

  localparam int unsigned DefAddrW = 10;
  localparam int unsigned DefDataW = 69;
  localparam int unsigned DefDepth = 256;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-side bus of the memory controller.
//   req_*  : request channel (valid/ready handshake, write flag, word address, write data)
//   rsp_*  : response channel (valid/ready handshake, read data, out-of-range error)
//   mem_*  : single-port RAM (address, write data, write enable, registered read data)
// Modports:
//   slave  : controller view (accepts requests, drives responses and the RAM)
//   master : requester + RAM view (drives requests, consumes responses, returns mem_q)
interface mem_ctrl_if
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_q,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data, mem_wren
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_q,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data, mem_wren
  );

endinterface

// File: rtl/mem_ctrl.sv
// Single-request-at-a-time controller for a single-port RAM with registered read data.
// Each accepted request walks IDLE -> ISSUE -> (WAIT for reads) -> RESP and produces exactly
// one response. All outputs except req_ready come straight from flops.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : mem_ctrl_if.slave (request, response and RAM signals)
// Optional feature: define MEM_CTRL_BOUNDS_CHECK_EN to reject addresses >= DEPTH with rsp_err=1
// without touching the RAM; otherwise every address goes to the RAM and rsp_err is tied to 0.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input logic       clock,
  input logic       reset,
  mem_ctrl_if.slave bus
);

  if (DEPTH == 0 || 64'(DEPTH) > (64'(1) << ADDR_W)) begin : g_depth_check
    $error("mem_ctrl: DEPTH must be in 1 .. 2**ADDR_W");
  end

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              addr_oob;

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  logic rsp_err_q, rsp_err_d;

  assign addr_oob    = (32'(bus.req_addr) >= DEPTH);
  assign bus.rsp_err = rsp_err_q;
`else
  assign addr_oob    = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = mem_wren_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
    rsp_err_d     = rsp_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d     = bus.req_write;
          rsp_rdata_d = '0;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
          rsp_err_d   = addr_oob;
`endif
          if (addr_oob) begin
            // Rejected request: answer next cycle, RAM never sees it.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
          end else begin
            // The mem_* registers double as the request latch.
            state_d       = StIssue;
            mem_address_d = bus.req_addr;
            mem_data_d    = bus.req_wdata;
            mem_wren_d    = bus.req_write;
          end
        end
      end

      StIssue: begin
        mem_wren_d = 1'b0;
        if (write_q) begin
          // RAM does not refresh q on a write, so writes skip WAIT entirely.
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = StWait;
        end
      end

      StWait: begin
        // RAM sampled the address at the end of ISSUE; q is valid now.
        rsp_rdata_d = bus.mem_q;
        state_d     = StResp;
        rsp_valid_d = 1'b1;
      end

      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      write_q       <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
      rsp_err_q     <= rsp_err_d;
`endif
    end
  end

  // No bypass: a request is only taken once the FSM is back in IDLE.
  assign bus.req_ready   = (state_q == StIdle);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_wren    = mem_wren_q;

endmodule
